// File: rtl/load_ext_if.sv
// Bundle of the load request, data-memory, device and response signals
// around the load extension pipe. The load unit uses the master view and
// its environment (request source, memory, device, consumer) the slave view.
interface load_ext_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        dev_req;
  logic [31:0] dev_addr;
  logic        dev_ack;
  logic [31:0] dev_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_adel;
  logic        rsp_tmo;

  modport master (
    input  req_valid, req_addr, req_op, mem_rdata, dev_ack, dev_rdata, rsp_ready,
    output req_ready, mem_re, mem_addr, dev_req, dev_addr,
           rsp_valid, rsp_data, rsp_adel, rsp_tmo
  );

  modport slave (
    output req_valid, req_addr, req_op, mem_rdata, dev_ack, dev_rdata, rsp_ready,
    input  req_ready, mem_re, mem_addr, dev_req, dev_addr,
           rsp_valid, rsp_data, rsp_adel, rsp_tmo
  );
endinterface

// File: rtl/load_ext_pipe.sv
// Load unit: accepts one load at a time, reads either the data memory
// (fixed one-cycle latency) or a memory-mapped device (handshake with a
// bounded wait), extends the selected lane and holds the result until the
// consumer takes it. Address/op errors are answered without any access.
module load_ext_pipe #(
  parameter logic [31:0] DEV_BASE  = 32'h0000_7F00,
  parameter logic [31:0] DEV_LIMIT = 32'h0000_7F1B,
  parameter int          TIMEOUT   = 15
) (
  input logic       clk,
  input logic       rst_n,
  load_ext_if.master bus
);

  typedef enum logic [1:0] {IDLE, MEM, DEV, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LH  = 3'd4;
  // Last value of the wait counter before giving up on the device.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  op_reg, op_next;
  logic [1:0]  lane_reg, lane_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] data_reg, data_next;
  logic        adel_reg, adel_next;
  logic        tmo_reg, tmo_next;
  logic [31:0] dev_addr_reg, dev_addr_next;

  logic        req_ready_c, mem_re_c, dev_req_c, rsp_valid_c;
  logic [31:0] mem_addr_c;
  logic        dev_hit, addr_err;

  // Select the byte/halfword lane and extend it according to the op.
  function automatic logic [31:0] extend(input logic [2:0] op, input logic [1:0] lane,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LBU:  r = {24'd0, b};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LHU:  r = {16'd0, h};
      OP_LH:   r = {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Classify the incoming request: device window hit and alignment/op errors.
  always_comb begin
    dev_hit  = (bus.req_addr >= DEV_BASE) && (bus.req_addr <= DEV_LIMIT);
    addr_err = (bus.req_op > OP_LH)
            || (((bus.req_op == OP_LHU) || (bus.req_op == OP_LH)) && bus.req_addr[0])
            || ((bus.req_op == OP_LW) && (bus.req_addr[1:0] != 2'b00))
            || (dev_hit && (bus.req_op != OP_LW));
  end

  // State register and all datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= 3'd0;
      lane_reg     <= 2'd0;
      cnt_reg      <= 8'd0;
      data_reg     <= 32'd0;
      adel_reg     <= 1'b0;
      tmo_reg      <= 1'b0;
      dev_addr_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      lane_reg     <= lane_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      adel_reg     <= adel_next;
      tmo_reg      <= tmo_next;
      dev_addr_reg <= dev_addr_next;
    end
  end

  // Next-state, datapath updates and strobes for each phase of a load.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    lane_next     = lane_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    adel_next     = adel_reg;
    tmo_next      = tmo_reg;
    dev_addr_next = dev_addr_reg;
    req_ready_c   = 1'b0;
    mem_re_c      = 1'b0;
    mem_addr_c    = 32'd0;
    dev_req_c     = 1'b0;
    rsp_valid_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held in IDLE by reset, so ready only once reset is released.
        req_ready_c = rst_n;
        if (rst_n && bus.req_valid) begin
          op_next   = bus.req_op;
          lane_next = bus.req_addr[1:0];
          adel_next = 1'b0;
          tmo_next  = 1'b0;
          if (addr_err) begin
            adel_next  = 1'b1;
            data_next  = 32'd0;
            state_next = RESP;
          end else if (dev_hit) begin
            cnt_next      = 8'd0;
            dev_addr_next = bus.req_addr;
            state_next    = DEV;
          end else begin
            mem_re_c   = 1'b1;
            mem_addr_c = {bus.req_addr[31:2], 2'b00};
            state_next = MEM;
          end
        end
      end
      MEM: begin
        data_next  = extend(op_reg, lane_reg, bus.mem_rdata);
        state_next = RESP;
      end
      DEV: begin
        dev_req_c = 1'b1;
        // An ack arriving on the final wait cycle still counts as success.
        if (bus.dev_ack) begin
          data_next  = bus.dev_rdata;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          tmo_next   = 1'b1;
          data_next  = 32'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.dev_req   = dev_req_c;
  assign bus.dev_addr  = dev_req_c ? dev_addr_reg : 32'd0;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = data_reg;
  assign bus.rsp_adel  = adel_reg;
  assign bus.rsp_tmo   = tmo_reg;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Bench for load_ext_pipe: directed scenarios plus a randomized run checked
// against an arithmetic reference model of the load rules.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_ext_if bus ();

  load_ext_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed results of the last transaction.
  logic [31:0] g_d, g_maddr, g_daddr;
  logic        g_a, g_t;
  int          g_lat, g_dcyc;
  bit          g_mem, g_ok, g_stable;

  // Expected results from the model.
  logic [31:0] e_d;
  logic        e_a, e_t;
  int          e_lat, e_dcyc;
  bit          e_mem;

  // Reference model: what a load should return, how long it should take,
  // how many cycles the device is asked and whether memory is read.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] w, input int ack_at,
                                output logic [31:0] d, output logic a, output logic t,
                                output int lat, output int dcyc, output bit mem);
    bit dev;
    dev = (addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F1B);
    d = 0; a = 0; t = 0; lat = 2; dcyc = 0; mem = 0;
    if (op > 4 || ((op == 3 || op == 4) && (addr % 2 != 0)) ||
        (op == 0 && (addr % 4 != 0)) || (dev && op != 0)) begin
      a = 1; lat = 1;
    end else if (dev) begin
      if (ack_at >= 1 && ack_at <= 15) begin
        d = w; lat = ack_at + 1; dcyc = ack_at;
      end else begin
        t = 1; lat = 16; dcyc = 15;
      end
    end else begin
      mem = 1;
      case (op)
        3'd0: d = w;
        3'd1: d = (w >> (8 * (addr % 4))) & 32'hFF;
        3'd2: begin
          d = (w >> (8 * (addr % 4))) & 32'hFF;
          if (d >= 128) d = d - 256;
        end
        3'd3: d = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        default: begin
          d = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
          if (d >= 32768) d = d - 65536;
        end
      endcase
    end
  endfunction

  // Drives one load from a point in the low clock phase, plays memory and
  // device, optionally stalls the response for 'hold' cycles, then consumes it.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input int ack_at, input int hold);
    bit rdy;
    bit got;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.mem_rdata = $urandom;
    bus.dev_ack   = 1'($urandom_range(0, 1));
    bus.dev_rdata = $urandom;
    #1;
    rdy = bus.req_ready;
    g_mem = bus.mem_re;
    g_maddr = bus.mem_addr;
    g_daddr = 32'hx;
    g_dcyc = 0;
    g_lat = 0;
    got = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_op    = 3'($urandom);
    bus.dev_ack   = 1'b0;
    bus.mem_rdata = word;
    g_lat = 1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      if (bus.mem_re) g_mem = 1;
      if (bus.dev_req) begin
        g_dcyc++;
        if (g_dcyc == 1) g_daddr = bus.dev_addr;
      end
      bus.dev_ack   = bus.dev_req && (g_dcyc == ack_at);
      bus.dev_rdata = bus.dev_ack ? word : $urandom;
      @(negedge clk);
      g_lat++;
      bus.mem_rdata = $urandom;
    end
    g_d = bus.rsp_data;
    g_a = bus.rsp_adel;
    g_t = bus.rsp_tmo;
    g_stable = 1;
    for (int i = 0; i < hold; i++) begin
      bus.dev_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_data !== g_d ||
          bus.rsp_adel !== g_a || bus.rsp_tmo !== g_t) g_stable = 0;
    end
    bus.dev_ack = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    g_ok = rdy && got && !bus.rsp_valid && bus.req_ready;
    $display("txn op=%0d addr=%h data=%h adel=%0b tmo=%0b lat=%0d devcyc=%0d",
             op, addr, g_d, g_a, g_t, g_lat, g_dcyc);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0000_0100;
    bus.rsp_ready = 1'b0;
    bus.dev_ack   = 1'b1;
    bus.dev_rdata = 32'h1234_5678;
    bus.mem_rdata = 32'h0;
    #12;
    n_checks++;
    if ({bus.req_ready, bus.mem_re, bus.dev_req, bus.rsp_valid, bus.rsp_adel, bus.rsp_tmo} !== 6'b0
        || bus.rsp_data !== 32'd0 || bus.mem_addr !== 32'd0 || bus.dev_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b re=%b dreq=%b vld=%b data=%h want all zero",
               bus.req_ready, bus.mem_re, bus.dev_req, bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.dev_ack   = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_mem_ext();
    // First load right after reset release: accepted on the first edge.
    run_txn(3'd2, 32'h0000_0003, 32'h80AB_CDEF, 0, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'hFFFF_FF80, 2'b00} || g_lat != 2 || !g_ok) begin
      n_fail++;
      $display("FAIL lb_sign: got data=%h adel=%b tmo=%b lat=%0d ok=%0b want ffffff80 0 0 2 1",
               g_d, g_a, g_t, g_lat, g_ok);
    end
    n_checks++;
    if (g_mem !== 1'b1 || g_maddr !== 32'h0) begin
      n_fail++;
      $display("FAIL lb_mem_addr: got re=%b addr=%h want 1 00000000", g_mem, g_maddr);
    end
    run_txn(3'd3, 32'h0000_0002, 32'h8001_1234, 0, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'h0000_8001, 2'b00} || g_lat != 2) begin
      n_fail++;
      $display("FAIL lhu_zero: got data=%h adel=%b lat=%0d want 00008001 0 2", g_d, g_a, g_lat);
    end
    run_txn(3'd4, 32'h0000_0001, 32'h8001_1234, 0, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'h0, 2'b10} || g_mem !== 1'b0 || g_lat != 1) begin
      n_fail++;
      $display("FAIL lh_misaligned: got data=%h adel=%b tmo=%b re=%b lat=%0d want 0 1 0 0 1",
               g_d, g_a, g_t, g_mem, g_lat);
    end
  endtask

  task automatic test_dev_ack();
    run_txn(3'd0, 32'h0000_7F04, 32'h0000_00AA, 4, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'h0000_00AA, 2'b00} || g_mem !== 1'b0 || g_dcyc != 4) begin
      n_fail++;
      $display("FAIL dev_ack_data: got data=%h adel=%b tmo=%b re=%b dcyc=%0d want 000000aa 0 0 0 4",
               g_d, g_a, g_t, g_mem, g_dcyc);
    end
    n_checks++;
    if (g_daddr !== 32'h0000_7F04) begin
      n_fail++;
      $display("FAIL dev_addr: got %h want 00007f04", g_daddr);
    end
  endtask

  task automatic test_timeout();
    run_txn(3'd0, 32'h0000_7F10, 32'hDEAD_BEEF, 0, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'h0, 2'b01} || g_dcyc != 15 || g_lat != 16) begin
      n_fail++;
      $display("FAIL dev_timeout: got data=%h adel=%b tmo=%b dcyc=%0d lat=%0d want 0 0 1 15 16",
               g_d, g_a, g_t, g_dcyc, g_lat);
    end
    run_txn(3'd0, 32'h0000_7F10, 32'hDEAD_BEEF, 15, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'hDEAD_BEEF, 2'b00} || g_dcyc != 15) begin
      n_fail++;
      $display("FAIL dev_ack_at_limit: got data=%h adel=%b tmo=%b dcyc=%0d want deadbeef 0 0 15",
               g_d, g_a, g_t, g_dcyc);
    end
  endtask

  task automatic test_backpressure();
    run_txn(3'd1, 32'h0000_0241, 32'h1122_3344, 0, 4);
    n_checks++;
    if (!g_stable || g_d !== 32'h0000_0033 || !g_ok) begin
      n_fail++;
      $display("FAIL hold_stable: got stable=%0b data=%h ok=%0b want 1 00000033 1",
               g_stable, g_d, g_ok);
    end
    run_txn(3'd1, 32'h0000_7F08, 32'h1122_3344, 1, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'h0, 2'b10} || g_dcyc != 0 || g_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL lbu_device: got data=%h adel=%b tmo=%b dcyc=%0d re=%b want 0 1 0 0 0",
               g_d, g_a, g_t, g_dcyc, g_mem);
    end
  endtask

  task automatic test_async_reset();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0000_7F10;
    bus.dev_ack   = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.dev_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_dev_req: got %b want 1", bus.dev_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.dev_req, bus.rsp_valid, bus.req_ready, bus.mem_re} !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset: got dreq=%b vld=%b rdy=%b re=%b want 0 0 0 0",
               bus.dev_req, bus.rsp_valid, bus.req_ready, bus.mem_re);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_txn(3'd0, 32'h0000_0100, 32'hCAFE_F00D, 0, 0);
    n_checks++;
    if ({g_d, g_a, g_t} !== {32'hCAFE_F00D, 2'b00} || g_lat != 2 || !g_ok) begin
      n_fail++;
      $display("FAIL after_reset_lw: got data=%h adel=%b tmo=%b lat=%0d ok=%0b want cafef00d 0 0 2 1",
               g_d, g_a, g_t, g_lat, g_ok);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr, w;
    int          ack_at, kind;
    for (int n = 0; n < 60; n++) begin
      op   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      if (kind == 0) addr = $urandom & 32'h0FFF_FFFF;
      else           addr = 32'h0000_7EF8 + 32'($urandom_range(0, 48));
      // Mostly keep the address aligned to the op so legal loads dominate.
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3'd0) addr[1:0] = 2'b00;
        else if (op == 3'd3 || op == 3'd4) addr[0] = 1'b0;
      end
      w      = $urandom;
      ack_at = $urandom_range(0, 17);
      model(op, addr, w, ack_at, e_d, e_a, e_t, e_lat, e_dcyc, e_mem);
      run_txn(op, addr, w, ack_at, $urandom_range(0, 2));
      n_checks++;
      if ({g_d, g_a, g_t} !== {e_d, e_a, e_t}) begin
        n_fail++;
        $display("FAIL rand_result[%0d] op=%0d addr=%h: got %h/%b/%b want %h/%b/%b",
                 n, op, addr, g_d, g_a, g_t, e_d, e_a, e_t);
      end
      n_checks++;
      if (g_lat != e_lat || g_dcyc != e_dcyc || g_mem != e_mem || !g_ok || !g_stable) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got lat=%0d dcyc=%0d re=%0b ok=%0b stable=%0b want %0d %0d %0b 1 1",
                 n, g_lat, g_dcyc, g_mem, g_ok, g_stable, e_lat, e_dcyc, e_mem);
      end
      n_checks++;
      if (e_mem && g_maddr !== {addr[31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL rand_mem_addr[%0d]: got %h want %h", n, g_maddr, {addr[31:2], 2'b00});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_7EFC;
    addrs[1] = 32'h0000_7F00;
    addrs[2] = 32'h0000_7F18;
    addrs[3] = 32'h0000_7F1C;
    for (int i = 0; i < 4; i++) begin
      model(3'd0, addrs[i], 32'h5A5A_0000 + 32'(i), 2, e_d, e_a, e_t, e_lat, e_dcyc, e_mem);
      run_txn(3'd0, addrs[i], 32'h5A5A_0000 + 32'(i), 2, 0);
      n_checks++;
      if (g_d !== e_d || g_mem != e_mem || g_dcyc != e_dcyc || !g_ok) begin
        n_fail++;
        $display("FAIL window_edge[%h]: got data=%h re=%0b dcyc=%0d ok=%0b want %h %0b %0d 1",
                 addrs[i], g_d, g_mem, g_dcyc, g_ok, e_d, e_mem, e_dcyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_ext();
    test_dev_ack();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
